multiword_add_sub_seq: RTL and testbench
========================================

# multiword_add_sub_seq

Sequencer that performs NUM_WORDS*DATA_WD-bit add/subtract by time-multiplexing one DATA_WD-bit ripple-carry adder over the operand words, LSW first. The carry is registered between words. The block sits in the programmable add/sub datapath wherever operand width exceeds the adder width. It trades latency for area, using a start/busy/done handshake.

## Interface
- DATA_WD, 4, width of the shared adder slice (one word)
- NUM_WORDS, 4, words per operand; must be ≥2
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_start  input  1  start request, sampled only in IDLE
- i_sub  input  1  0 = a+b, 1 = a−b; sampled with i_start
- i_a  input  NUM_WORDS*DATA_WD  operand a, sampled with i_start
- i_b  input  NUM_WORDS*DATA_WD  operand b, sampled with i_start
- o_busy  output  1  high while state ≠ IDLE
- o_done  output  1  one-cycle pulse, result valid
- o_result  output  NUM_WORDS*DATA_WD  full-width result
- o_carry  output  1  final carry out; for subtract, 1 = no borrow (a ≥ b unsigned)
- o_ovf  output  1  signed overflow (present only with the macro, see Configuration)
- Clocking and reset: one clock; reset is synchronous and active-high.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on i_start.
  - RUN→DONE when word index = NUM_WORDS−1.
  - DONE→IDLE unconditionally.
- On accepted start:
  - Latch a.
  - Latch b_eff = i_sub ? ~i_b : i_b.
  - Carry register = i_sub.
  - Word index = 0.
- Each RUN cycle:
  - Adder computes a[idx] + b_eff[idx] + carry.
  - Low DATA_WD bits are written to o_result word idx.
  - Bit DATA_WD is written to the carry register.
  - idx increments.
- o_carry is the carry register after the last word. It is updated only on the last-word edge.
- o_result words are overwritten progressively. o_result is defined only while o_done=1 or in IDLE after a completed operation, and holds until the next start.
- i_start while busy (RUN or DONE) is ignored and not queued.
- Word index counter width is clog2(NUM_WORDS), min 1. Wrap is never reached because the FSM leaves RUN at NUM_WORDS−1.

## Timing
- Reset values: state IDLE, o_busy 0, o_done 0, o_result 0, o_carry 0, o_ovf 0, idx 0.
- Start sampled at edge E0 → words 0..NUM_WORDS−1 written at edges E1..E(NUM_WORDS).
- o_done=1 for exactly one cycle, following edge E(NUM_WORDS).
- o_busy=1 from after E0 through the o_done cycle (NUM_WORDS+1 cycles).
- A new start is accepted at the edge ending the DONE cycle's successor (first IDLE cycle). Minimum issue interval is NUM_WORDS+2 cycles.
- i_rst mid-operation: at the next edge, all state and outputs return to reset values and the operation is discarded. i_rst has priority over i_start.

## Configuration
- MULTIWORD_ADD_SUB_OVF_EN:
  - Defined: o_ovf port exists. It is registered on the last-word edge as (a_msb == b_eff_msb) && (sum_msb != a_msb), i.e. two's-complement overflow of the full-width result.
  - Undefined: no o_ovf port and no overflow logic.

## Structure
- Shared package multiword_add_sub_pkg holds:
  - the FSM state enum typedef (IDLE/RUN/DONE);
  - the default DATA_WD and NUM_WORDS constants.
- One sub-module, ripple_carry_adder (DATA_WD parameter, i_a/i_b/i_c in, o_arith_out DATA_WD+1 bits), instantiated once as the shared slice.
- Word muxing, carry register and FSM live in the top.

## Test plan
Defaults DATA_WD=4, NUM_WORDS=4 unless stated.
- Add: a=0x1234, b=0x0FFF, sub=0 → o_result 0x2233, o_carry 0, o_ovf 0. o_done exactly 4 edges after the start edge, o_busy high 5 cycles.
- Carry chain: a=0xFFFF, b=0x0001, sub=0 → o_result 0x0000, o_carry 1, o_ovf 0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 → o_result 0xFFFE, o_carry 0. Subtract without borrow: a=0x0007, b=0x0005 → o_result 0x0002, o_carry 1.
- Signed overflow (macro on): a=0x7FFF, b=0x0001, sub=0 → o_result 0x8000, o_ovf 1. Then a=0x8000, b=0x0001, sub=1 → o_result 0x7FFF, o_ovf 1.
- Start while busy: second i_start with a=0xAAAA during RUN → ignored, first result unchanged. Start held in the first IDLE cycle after done → accepted.
- Reset mid-op: i_rst during second RUN cycle → next cycle o_busy 0, o_done 0, o_result 0. Subsequent 0x0001+0x0001 → 0x0002 with normal timing.

Source files
------------

// File: rtl/multiword_add_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_sub_pkg
// Purpose  : Shared types and default sizing for the multi-word add/sub
//            sequencer. This file holds the FSM state encoding and the default
//            word width and word count.
// Revision : 1.0 - initial release
// ============================================================================
package multiword_add_sub_pkg;

  // Default width of the shared adder slice, in bits.
  localparam int DEF_DATA_WD   = 4;
  // Default number of words in each operand.
  localparam int DEF_NUM_WORDS = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : multiword_add_sub_pkg
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module   : ripple_carry_adder
// Purpose  : Combinational DATA_WD-bit ripple-carry adder with a carry in.
//            The sequencer uses one instance as its shared slice.
// Ports    : i_a, i_b    [DATA_WD-1:0] addends
//            i_c         carry in
//            o_arith_out [DATA_WD:0]   sum; the MSB is the carry out
// Revision : 1.0 - initial release
// ============================================================================
module ripple_carry_adder
  import multiword_add_sub_pkg::*;
#(
  parameter int DATA_WD = DEF_DATA_WD
) (
  input  logic [DATA_WD-1:0] i_a,
  input  logic [DATA_WD-1:0] i_b,
  input  logic               i_c,
  output logic [DATA_WD:0]   o_arith_out
);

  // carry[i] is the carry into bit i.
  logic [DATA_WD:0] carry;

  assign carry[0] = i_c;

  for (genvar i = 0; i < DATA_WD; i++) begin : g_bit
    assign o_arith_out[i] = i_a[i] ^ i_b[i] ^ carry[i];
    assign carry[i+1]     = (i_a[i] & i_b[i]) | (carry[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_arith_out[DATA_WD] = carry[DATA_WD];

endmodule : ripple_carry_adder
`default_nettype wire

// File: rtl/multiword_add_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_sub_seq
// Purpose  : Performs NUM_WORDS*DATA_WD-bit add/subtract by sending the
//            operand words, least significant word first, through one shared
//            DATA_WD-bit ripple-carry adder. The carry is registered between
//            words. The block uses a start/busy/done handshake.
// Ports    : i_clk, i_rst   clock; synchronous active-high reset
//            i_start        start request, sampled only in IDLE
//            i_sub          0 = a+b, 1 = a-b (sampled with i_start)
//            i_a, i_b       operands (sampled with i_start)
//            o_busy         high while not IDLE
//            o_done         one-cycle pulse when o_result is valid
//            o_result       full-width result
//            o_carry        final carry out (for subtract, 1 = no borrow)
//            o_ovf          signed overflow; exists only when
//                           MULTIWORD_ADD_SUB_OVF_EN is defined
// Config   : `define MULTIWORD_ADD_SUB_OVF_EN to add the o_ovf port and the
//            overflow logic.
// Revision : 1.0 - initial release
// ============================================================================
module multiword_add_sub_seq
  import multiword_add_sub_pkg::*;
#(
  parameter int DATA_WD   = DEF_DATA_WD,
  parameter int NUM_WORDS = DEF_NUM_WORDS   // must be >= 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_sub,
  input  logic [NUM_WORDS*DATA_WD-1:0]   i_a,
  input  logic [NUM_WORDS*DATA_WD-1:0]   i_b,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [NUM_WORDS*DATA_WD-1:0]   o_result,
  output logic                           o_carry
`ifdef MULTIWORD_ADD_SUB_OVF_EN
  ,
  output logic                           o_ovf
`endif
);

  localparam int TOT_WD = NUM_WORDS * DATA_WD;
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [TOT_WD-1:0]   a_q;
  logic [TOT_WD-1:0]   b_q;          // holds b, or ~b for subtract
  logic                carry_q;      // carry between words
  logic [TOT_WD-1:0]   result_q;
  logic                carry_out_q;  // final carry, changes only on the last word
  logic                busy_q;
  logic                done_q;
`ifdef MULTIWORD_ADD_SUB_OVF_EN
  logic                ovf_q;
`endif

  logic [DATA_WD-1:0]  a_word;
  logic [DATA_WD-1:0]  b_word;
  logic [DATA_WD:0]    add_out;
  logic                last_word;

  // Select the current word of each operand for the shared slice.
  assign a_word    = a_q[int'(idx_q)*DATA_WD +: DATA_WD];
  assign b_word    = b_q[int'(idx_q)*DATA_WD +: DATA_WD];
  assign last_word = (idx_q == LAST_IDX);

  ripple_carry_adder #(
    .DATA_WD (DATA_WD)
  ) u_slice (
    .i_a         (a_word),
    .i_b         (b_word),
    .i_c         (carry_q),
    .o_arith_out (add_out)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MULTIWORD_ADD_SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            a_q     <= i_a;
            // Subtract is a + ~b + 1. The +1 goes in through the carry-in of word 0.
            b_q     <= i_sub ? ~i_b : i_b;
            carry_q <= i_sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_q[int'(idx_q)*DATA_WD +: DATA_WD] <= add_out[DATA_WD-1:0];
          carry_q <= add_out[DATA_WD];
          if (last_word) begin
            carry_out_q <= add_out[DATA_WD];
`ifdef MULTIWORD_ADD_SUB_OVF_EN
            // Overflow: the operand signs match and the sign of the sum differs.
            ovf_q <= (a_q[TOT_WD-1] == b_q[TOT_WD-1]) &&
                     (add_out[DATA_WD-1] != a_q[TOT_WD-1]);
`endif
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_carry  = carry_out_q;
`ifdef MULTIWORD_ADD_SUB_OVF_EN
  assign o_ovf    = ovf_q;
`endif

endmodule : multiword_add_sub_seq
`default_nettype wire

// File: tb/tb_multiword_add_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiword_add_sub_seq
// Purpose  : Directed self-checking bench for multiword_add_sub_seq using the
//            default sizing (DATA_WD=4, NUM_WORDS=4). The expected values are
//            worked out by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiword_add_sub_seq;

  localparam int DATA_WD   = 4;
  localparam int NUM_WORDS = 4;
  localparam int TOT_WD    = DATA_WD * NUM_WORDS;
  localparam int MAX_WAIT  = 30;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic              i_sub;
  logic [TOT_WD-1:0] i_a;
  logic [TOT_WD-1:0] i_b;
  logic              o_busy;
  logic              o_done;
  logic [TOT_WD-1:0] o_result;
  logic              o_carry;
`ifdef MULTIWORD_ADD_SUB_OVF_EN
  logic              o_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  multiword_add_sub_seq #(
    .DATA_WD   (DATA_WD),
    .NUM_WORDS (NUM_WORDS)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_sub    (i_sub),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_carry  (o_carry)
`ifdef MULTIWORD_ADD_SUB_OVF_EN
    ,
    .o_ovf    (o_ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait on negedges until o_done is seen. Returns the number of negedges
  // waited and how many of them had o_busy high.
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (n < MAX_WAIT) begin
      @(negedge i_clk);
      n++;
      if (o_busy) nbusy++;
      if (o_done) break;
    end
  endtask

  // Issue one operation starting at a negedge. Return after the o_done cycle
  // is observed. lat is the number of edges from the start edge to the done edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output int lat, output int nbusy);
    int n;
    @(negedge i_clk);
    i_a = a; i_b = b; i_sub = sub; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    wait_done(n, nbusy);
    lat = n - 1;
  endtask

  initial begin
    int lat, nb, n;
    i_rst = 1'b1; i_start = 1'b0; i_sub = 1'b0; i_a = '0; i_b = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_busy",   32'(o_busy),   32'd0);
    check("rst_done",   32'(o_done),   32'd0);
    check("rst_result", 32'(o_result), 32'h0);
    check("rst_carry",  32'(o_carry),  32'd0);
`ifdef MULTIWORD_ADD_SUB_OVF_EN
    check("rst_ovf",    32'(o_ovf),    32'd0);
`endif

    // Plain add with timing checks
    run_op(16'h1234, 16'h0FFF, 1'b0, lat, nb);
    check("add_latency", 32'(lat), 32'd4);
    check("add_busy_cycles", 32'(nb), 32'd5);
    check("add_result", 32'(o_result), 32'h2233);
    check("add_carry",  32'(o_carry),  32'd0);
`ifdef MULTIWORD_ADD_SUB_OVF_EN
    check("add_ovf",    32'(o_ovf),    32'd0);
`endif
    @(negedge i_clk);
    check("add_done_pulse", 32'(o_done), 32'd0);
    check("add_idle_busy",  32'(o_busy), 32'd0);
    check("add_hold",       32'(o_result), 32'h2233);

    // Carry through every word
    run_op(16'hFFFF, 16'h0001, 1'b0, lat, nb);
    check("chain_result", 32'(o_result), 32'h0000);
    check("chain_carry",  32'(o_carry),  32'd1);
`ifdef MULTIWORD_ADD_SUB_OVF_EN
    check("chain_ovf",    32'(o_ovf),    32'd0);
`endif

    // Subtract with borrow, then without borrow
    run_op(16'h0005, 16'h0007, 1'b1, lat, nb);
    check("sub_borrow_result", 32'(o_result), 32'hFFFE);
    check("sub_borrow_carry",  32'(o_carry),  32'd0);
    run_op(16'h0007, 16'h0005, 1'b1, lat, nb);
    check("sub_nb_result", 32'(o_result), 32'h0002);
    check("sub_nb_carry",  32'(o_carry),  32'd1);

    // Signed overflow cases
    run_op(16'h7FFF, 16'h0001, 1'b0, lat, nb);
    check("ovf_add_result", 32'(o_result), 32'h8000);
    check("ovf_add_carry",  32'(o_carry),  32'd0);
`ifdef MULTIWORD_ADD_SUB_OVF_EN
    check("ovf_add_ovf",    32'(o_ovf),    32'd1);
`endif
    run_op(16'h8000, 16'h0001, 1'b1, lat, nb);
    check("ovf_sub_result", 32'(o_result), 32'h7FFF);
    check("ovf_sub_carry",  32'(o_carry),  32'd1);
`ifdef MULTIWORD_ADD_SUB_OVF_EN
    check("ovf_sub_ovf",    32'(o_ovf),    32'd1);
`endif

    // Start while busy is ignored. A start held into the first IDLE cycle is accepted.
    @(negedge i_clk);
    i_a = 16'h1234; i_b = 16'h0FFF; i_sub = 1'b0; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_a = 16'hAAAA; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    wait_done(n, nb);
    check("busy_start_result", 32'(o_result), 32'h2233);
    i_a = 16'h0001; i_b = 16'h0001; i_sub = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    check("done_cycle_ignored", 32'(o_busy), 32'd0);
    @(posedge i_clk);
    #1 i_start = 1'b0;
    wait_done(n, nb);
    check("idle_start_latency", 32'(n - 1), 32'd4);
    check("idle_start_result",  32'(o_result), 32'h0002);

    // Reset during the second RUN cycle. Start is also held high to check that reset wins.
    @(negedge i_clk);
    i_a = 16'h1234; i_b = 16'h0FFF; i_sub = 1'b0; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0; i_start = 1'b0;
    @(negedge i_clk);
    check("midrst_busy",   32'(o_busy),   32'd0);
    check("midrst_done",   32'(o_done),   32'd0);
    check("midrst_result", 32'(o_result), 32'h0);
    run_op(16'h0001, 16'h0001, 1'b0, lat, nb);
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_result",  32'(o_result), 32'h0002);
    check("post_rst_carry",   32'(o_carry),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_multiword_add_sub_seq
`default_nettype wire
